// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: opcode enum, command struct,
// sequencer state enum and the default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_INC  = 3'b010,
    ALU_DEC  = 3'b011,
    ALU_PASS = 3'b100,
    ALU_NOT  = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_e;

  // Operand fields are fixed at ALU_WIDTH; the sequencer's WIDTH must match.
  typedef struct packed {
    logic [ALU_WIDTH-1:0] a;
    logic [ALU_WIDTH-1:0] b;
    alu_op_e              op;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_EXEC = 2'd1,
    SEQ_RESP = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of the command, ALU and response buses around alu_cmd_sequencer.
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// sender holds its payload stable while valid is high and ready is low.
// The ALU side is enable/ack: alu_enable stays high until alu_ack is seen.
interface alu_cmd_sequencer_if import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [2:0]       cmd_op;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_opcode;
  logic             alu_enable;
  logic [WIDTH-1:0] alu_result;
  logic             alu_ack;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [2:0]       rsp_op;
  logic             rsp_err;

  logic             busy;
  logic [CW-1:0]    count;

  // Environment side: producer, ALU and consumer.
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, alu_ack, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_opcode, alu_enable,
           rsp_valid, rsp_result, rsp_op, rsp_err, busy, count
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, alu_ack, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_opcode, alu_enable,
           rsp_valid, rsp_result, rsp_op, rsp_err, busy, count
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with occupancy, full and empty flags.
// Pointers wrap naturally because DEPTH is a power of two.
module alu_cmd_fifo import alu_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  alu_cmd_t               wdata,
  input  logic                   pop,
  output alu_cmd_t               rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  alu_cmd_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer and occupancy updates; push and pop together leave count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command queue and issue controller in front of an enable/ack ALU.
// Commands are queued, issued one at a time, and the ALU result is captured
// only on ack so a floating result bus never reaches the response port.
// Optional feature: define ALU_SEQ_TIMEOUT_EN to abandon an operation after
// TIMEOUT EXEC cycles without ack, returning rsp_err=1 and rsp_result=0.
module alu_cmd_sequencer import alu_pkg::*; #(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_cmd_sequencer_if.slave  bus,
  output seq_state_e          dbg_state
);
  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             alu_en_q, alu_en_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [2:0]       rsp_op_q, rsp_op_d;
  logic             fifo_pop, fifo_full, fifo_empty;
  alu_cmd_t         fifo_wdata, fifo_rdata;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  logic [TW-1:0] timer_q, timer_d;
  logic          rsp_err_q, rsp_err_d;
`endif

  assign fifo_wdata = '{a: bus.cmd_a, b: bus.cmd_b, op: alu_op_e'(bus.cmd_op)};

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.cmd_valid && bus.cmd_ready),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (bus.count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state and datapath loads for the IDLE -> EXEC -> RESP issue loop.
  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    alu_en_d     = alu_en_q;
    rsp_result_d = rsp_result_q;
    rsp_op_d     = rsp_op_q;
    fifo_pop     = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
    timer_d      = timer_q;
    rsp_err_d    = rsp_err_q;
`endif
    case (state_q)
      SEQ_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          alu_a_d  = fifo_rdata.a;
          alu_b_d  = fifo_rdata.b;
          alu_op_d = fifo_rdata.op;
          alu_en_d = 1'b1;
          state_d  = SEQ_EXEC;
`ifdef ALU_SEQ_TIMEOUT_EN
          timer_d  = '0;
`endif
        end
      end
      SEQ_EXEC: begin
        if (bus.alu_ack) begin
          rsp_result_d = bus.alu_result;
          rsp_op_d     = alu_op_q;
          alu_en_d     = 1'b0;
          state_d      = SEQ_RESP;
`ifdef ALU_SEQ_TIMEOUT_EN
          rsp_err_d    = 1'b0;
        end else if (timer_q == TMR_LAST) begin
          rsp_result_d = '0;
          rsp_op_d     = alu_op_q;
          rsp_err_d    = 1'b1;
          alu_en_d     = 1'b0;
          state_d      = SEQ_RESP;
        end else begin
          timer_d      = timer_q + TMR_ONE;
`endif
        end
      end
      SEQ_RESP: begin
        if (bus.rsp_ready) state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= SEQ_IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      alu_en_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_op_q     <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_en_q     <= alu_en_d;
      rsp_result_q <= rsp_result_d;
      rsp_op_q     <= rsp_op_d;
    end
  end

`ifdef ALU_SEQ_TIMEOUT_EN
  // EXEC cycle counter and timeout flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.cmd_ready  = rst_n && !fifo_full;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_opcode = alu_op_q;
  assign bus.alu_enable = alu_en_q;
  assign bus.rsp_valid  = (state_q == SEQ_RESP);
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_op     = rsp_op_q;
  assign bus.busy       = (state_q != SEQ_IDLE) || !fifo_empty;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed and randomized bench for alu_cmd_sequencer with a behavioural
// enable/ack ALU and an in-order scoreboard of expected responses.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  seq_state_e dbg_state;

  alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural ALU ----------------
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a + 32'd1;
      3'd3:    return a - 32'd1;
      3'd4:    return a;
      3'd5:    return ~a;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  logic        alu_live = 1'b1;
  logic [31:0] garbage;
  always @(negedge clk) garbage <= $urandom();
  assign bus.alu_ack    = bus.alu_enable && alu_live;
  assign bus.alu_result = bus.alu_ack ? alu_ref(bus.alu_a, bus.alu_b, bus.alu_opcode) : garbage;

  // ---------------- scoreboard ----------------
  logic [35:0] exp_q[$];
  logic [31:0] rsp_log[$];
  bit          model_timeout = 1'b0;
  int          en_run = 0;
  int          last_run = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      en_run = 0;
    end else begin
      if (bus.cmd_valid && bus.cmd_ready)
        exp_q.push_back(model_timeout ? {1'b1, bus.cmd_op, 32'h0}
                                      : {1'b0, bus.cmd_op, alu_ref(bus.cmd_a, bus.cmd_b, bus.cmd_op)});
      if (bus.rsp_valid && bus.rsp_ready) begin
        check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0)
          check("rsp_payload", 64'({bus.rsp_err, bus.rsp_op, bus.rsp_result}), 64'(exp_q.pop_front()));
        rsp_log.push_back(bus.rsp_result);
      end
      if (bus.alu_enable) en_run++;
      else if (en_run != 0) begin
        last_run = en_run;
        en_run = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bit ok = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_op = op;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("push_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_drain(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.busy && !bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd0);
    check({tag, "_alu"}, 64'({bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_enable}), 64'd0);
    check({tag, "_rsp"}, 64'({bus.rsp_valid, bus.rsp_result, bus.rsp_op, bus.rsp_err}), 64'd0);
    check({tag, "_busy_count"}, 64'({bus.busy, bus.count}), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  logic [31:0] exp8 [8];
  logic [31:0] held_r;
  logic [2:0]  held_o;
  int          k;
  bit          seen;
  bit          rnd_done;

  initial begin
    exp8 = '{32'd15, 32'd5, 32'd11, 32'd9, 32'd10, 32'hFFFFFFF5, 32'd15, 32'd0};
    bus.cmd_valid = 1'b1;
    bus.cmd_a = 32'd1;
    bus.cmd_b = 32'd2;
    bus.cmd_op = 3'd0;
    bus.rsp_ready = 1'b1;

    // Reset held two cycles with a command offered.
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
    end
    check("reset_state", 64'(dbg_state), 64'(SEQ_IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("release_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("release_count", 64'(bus.count), 64'd0);

    // Single command: latency and enable width.
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_a = 32'd10;
    bus.cmd_b = 32'd5;
    bus.cmd_op = 3'd0;
    @(negedge clk);
    check("single_accept", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("single_t1", 64'({bus.alu_enable, bus.rsp_valid}), 64'd0);
    @(negedge clk);
    check("single_t2_enable", 64'(bus.alu_enable), 64'd1);
    check("single_t2_rsp", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    check("single_t3_rsp", 64'({bus.rsp_valid, bus.rsp_op, bus.rsp_result}), 64'({1'b1, 3'd0, 32'd15}));
    check("single_t3_enable", 64'(bus.alu_enable), 64'd0);
    @(negedge clk);
    check("single_enable_width", 64'(last_run), 64'd1);
    check("single_done", 64'(bus.rsp_valid), 64'd0);

    // Eight back-to-back commands with the consumer stalled.
    rsp_log.delete();
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      bus.cmd_valid = (k < 8);
      bus.cmd_a = 32'd10;
      bus.cmd_b = 32'd5;
      bus.cmd_op = 3'(k);
      @(negedge clk);
      if (bus.cmd_valid && bus.cmd_ready) k++;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_accepted", 64'(k), 64'd5);
    check("b2b_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("b2b_count", 64'(bus.count), 64'd4);
    check("b2b_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    for (int j = 5; j < 8; j++) push(32'd10, 32'd5, 3'(j));
    wait_drain("b2b_drain");
    check("b2b_rsp_count", 64'(rsp_log.size()), 64'd8);
    for (int j = 0; j < 8; j++)
      if (j < rsp_log.size()) check("b2b_order", 64'(rsp_log[j]), 64'(exp8[j]));

    // Backpressure: response held for 10 cycles while the FIFO fills.
    bus.rsp_ready = 1'b0;
    push(32'd7, 32'd3, 3'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_rsp_seen", 64'(seen), 64'd1);
    held_r = bus.rsp_result;
    held_o = bus.rsp_op;
    check("bp_result", 64'(held_r), 64'd10);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.cmd_valid = (i < 3);
      bus.cmd_a = $urandom();
      bus.cmd_b = $urandom();
      bus.cmd_op = 3'($urandom_range(0, 7));
      @(negedge clk);
      check("bp_hold", 64'({bus.rsp_valid, bus.rsp_op, bus.rsp_result}), 64'({1'b1, held_o, held_r}));
      check("bp_enable_low", 64'(bus.alu_enable), 64'd0);
      if (i < 3) check("bp_fifo_accepts", 64'(bus.cmd_ready), 64'd1);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("bp_count", 64'(bus.count), 64'd3);
    bus.rsp_ready = 1'b1;
    wait_drain("bp_drain");

`ifdef ALU_SEQ_TIMEOUT_EN
    // Dead ALU: timeout response, then a live ALU completes normally.
    alu_live = 1'b0;
    model_timeout = 1'b1;
    push(32'd1, 32'd2, 3'd0);
    model_timeout = 1'b0;
    wait_drain("timeout_drain");
    check("timeout_exec_cycles", 64'(last_run), 64'(TIMEOUT));
    alu_live = 1'b1;
    push(32'd20, 32'd22, 3'd1);
    wait_drain("after_timeout_drain");
    check("after_timeout_exec_cycles", 64'(last_run), 64'd1);
`else
    // Slow ALU: EXEC waits for ack with no time limit.
    alu_live = 1'b0;
    push(32'd1, 32'd2, 3'd0);
    repeat (30) @(negedge clk);
    check("stall_enable", 64'(bus.alu_enable), 64'd1);
    check("stall_no_rsp", 64'(bus.rsp_valid), 64'd0);
    alu_live = 1'b1;
    wait_drain("stall_drain");
`endif

    // Randomized traffic with random consumer stalls and ALU ack delays.
    rnd_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 40; n++)
          push($urandom(), $urandom(), 3'($urandom_range(0, 7)));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.rsp_ready = ($urandom_range(0, 3) != 0);
          alu_live = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.rsp_ready = 1'b1;
    alu_live = 1'b1;
    wait_drain("random_drain");

    // Reset mid-EXEC with three commands queued.
    alu_live = 1'b0;
    for (int j = 0; j < 4; j++) push(32'(j + 100), 32'd1, 3'd0);
    @(negedge clk);
    check("mid_exec_enable", 64'(bus.alu_enable), 64'd1);
    check("mid_exec_count", 64'(bus.count), 64'd3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_exec_enable", 64'(bus.alu_enable), 64'd0);
    check("rst_exec_count", 64'(bus.count), 64'd0);
    check("rst_exec_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    alu_live = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("rst_no_rsp", 64'({bus.rsp_valid, bus.busy}), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-queue and issue controller sitting directly upstream of the 32-bit ALU with enable/ack. It buffers operand/opcode commands from a producer and issues them to the ALU one at a time, asserting `alu_enable` only while an operation is in flight. It captures the result on `alu_ack` and presents it on a valid/ready response port, so the rest of the design never samples the ALU's tri-stated result bus.

## Interface
- `WIDTH`, 32: operand/result width.
- `DEPTH`, 4: command FIFO entries; power of 2, at least 2.
- `TIMEOUT`, 15: maximum EXEC cycles without ack. Used only when `ALU_SEQ_TIMEOUT_EN` is defined.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: FIFO can accept a command; equals `!full`; 0 while `rst_n`=0.
- `cmd_a`, `cmd_b`  in  WIDTH: operands.
- `cmd_op`  in  3: ALU opcode.
- `alu_a`, `alu_b`  out  WIDTH: registered operands to the ALU.
- `alu_opcode`  out  3: registered opcode.
- `alu_enable`  out  1: registered; high only in EXEC.
- `alu_result`  in  WIDTH: ALU result; may be Z/X when disabled.
- `alu_ack`  in  1: ALU result valid.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_result`  out  WIDTH: captured result.
- `rsp_op`  out  3: opcode echo.
- `rsp_err`  out  1: timeout flag; tied to 0 without the macro.
- `busy`  out  1: FSM not in IDLE, or FIFO non-empty.
- `count`  out  $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Push when `cmd_valid && cmd_ready`. There is no bypass: a pushed entry becomes visible to the FSM the following cycle.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if FIFO non-empty, pop the head, load `alu_a`/`alu_b`/`alu_opcode`, go to EXEC. Otherwise stay.
  - EXEC: `alu_enable`=1. On `alu_ack`=1, register `alu_result` into `rsp_result` and the opcode into `rsp_op`, clear `rsp_err`, go to RESP.
  - RESP: `rsp_valid`=1, `alu_enable`=0. `rsp_result`, `rsp_op` and `rsp_err` are held stable until `rsp_ready`=1, then go to IDLE.
- `alu_result` is sampled only in EXEC with `alu_ack`=1. Z/X on the bus at any other time never propagates.
- Ordering: responses are returned strictly in command order; one operation in flight at a time.
- Simultaneous push and pop in the same cycle are both honoured; `count` stays unchanged.
- FIFO pointers wrap modulo DEPTH.
- Reset (`rst_n`=0 at a rising edge) applies in any state, including mid-EXEC or RESP:
  - FIFO flushed, `count`=0, FSM returns to IDLE.
  - All outputs go to 0: `alu_*`, `rsp_*`, `busy`, and `cmd_ready` (which is 0 during reset).
  - The in-flight operation is abandoned with no response.

## Timing
- Command accepted at cycle t into an empty, idle block:
  - t+1: pop.
  - t+2: EXEC with `alu_enable`=1; ALU ack is combinational.
  - t+3: `rsp_valid`=1.
- Minimum latency is 3 cycles; throughput is one command per 3 cycles with `rsp_ready` held high.
- The RESP to IDLE transition costs one cycle; the next pop happens in that IDLE cycle.
- Capacity before `cmd_ready` drops with the consumer stalled: DEPTH + 1 commands (DEPTH queued plus one in the sequencer).
- `cmd_ready` rises in the cycle after a pop from a full FIFO.

## Configuration
- `ALU_SEQ_TIMEOUT_EN` defined:
  - A cycle counter runs in EXEC and is cleared on entry.
  - If TIMEOUT cycles elapse without `alu_ack`, go to RESP with `rsp_result`=0 and `rsp_err`=1; `alu_enable` drops.
- `ALU_SEQ_TIMEOUT_EN` undefined:
  - No counter; EXEC waits for ack indefinitely.
  - `rsp_err` is tied to 0.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_e`, a 3-bit enum: ADD=000, SUB=001, INC=010, DEC=011, PASS=100, NOT=101, OR=110, AND=111.
  - `alu_cmd_t`, a struct of a, b and op.
  - State enum `seq_state_e`.
  - Default WIDTH constant.
- One sub-module, `alu_cmd_fifo`: synchronous FIFO of `alu_cmd_t` with count, full and empty outputs, same clock and reset.

## Test plan
- Reset: `rst_n` low 2 cycles while commands are offered -> every output 0, nothing accepted; `cmd_ready`=1 on the first cycle after release.
- Single command A=10, B=5, op=000, `rsp_ready`=1, behavioural ALU -> `rsp_valid` at t+3 with `rsp_result`=15, `rsp_op`=000; `alu_enable` high exactly 1 cycle.
- Eight back-to-back commands A=10, B=5, op 000..111, `rsp_ready`=0 -> 5 accepted, then `cmd_ready`=0. Then `rsp_ready`=1 -> results in order 15, 5, 11, 9, 10, 0xFFFFFFF5, 15, 0.
- Backpressure: `rsp_ready` low for 10 cycles during RESP -> `rsp_valid`, `rsp_result` and `rsp_op` stable, `alu_enable`=0, FIFO still accepts.
- Timeout (macro defined), ALU stub with `alu_ack`=0 -> after 15 EXEC cycles `rsp_valid`=1, `rsp_err`=1, `rsp_result`=0. The next command with a live ALU completes normally with `rsp_err`=0.
- Reset mid-EXEC with 3 commands queued -> next cycle `alu_enable`=0, `count`=0, `busy`=0; no response after release.
